// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding unit for the five-stage MIPS pipeline.
//
// The unit keeps its own shadow copy of the E/M/W destination register and
// Tnew state. It advances that copy every cycle from the D-stage decode
// fields. It stalls D when a source operand cannot be produced in time.
// It drives every forwarding-mux select in the datapath.
//
// Ports
//   clk, reset            core clock; asynchronous active-high reset
//   d_rs, d_rt            D-stage source register numbers
//   d_tuse_rs, d_tuse_rt  cycles until each source is consumed (3 = unused)
//   d_tnew                Tnew carried by the D instruction on entering E
//   d_a3, d_regwrite      D-stage destination register and write enable
//   stall                 freeze PC/D register, inject a bubble into E
//   fwd_rs_d, fwd_rt_d    D operand select: 0 GRF, 1 E, 2 M, 3 W
//   fwd_rs_e, fwd_rt_e    ALU operand select: 0 carried, 1 M, 2 W
//   fwd_rt_m              DM write-data select: 0 carried, 1 W
//   stall_cnt             number of stall cycles since reset (wraps)
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic [1:0]       d_tnew,
    input  logic [4:0]       d_a3,
    input  logic             d_regwrite,
    output logic             stall,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e,
    output logic             fwd_rt_m,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Shadow pipeline state
    logic [4:0]       e_a3_q, e_rs_q, e_rt_q;
    logic [1:0]       e_tnew_q, e_tuse_rs_q, e_tuse_rt_q;
    logic             e_wr_q;
    logic [4:0]       m_a3_q, m_rt_q;
    logic [1:0]       m_tnew_q;
    logic             m_wr_q;
    logic [4:0]       w_a3_q;
    logic [1:0]       w_tnew_q;
    logic             w_wr_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic e_live, m_live, w_live;

    assign e_live = e_wr_q && (e_a3_q != '0);
    assign m_live = m_wr_q && (m_a3_q != '0);
    assign w_live = w_wr_q && (w_a3_q != '0);

    // Resolve one D source against the youngest matching stage.
    // Returns {stall, select}. An older match is never considered once a
    // younger one hits, even when the younger one is not ready yet.
    function automatic logic [2:0] d_eval(
        input logic       hit_e,
        input logic       hit_m,
        input logic       hit_w,
        input logic [1:0] tn_e,
        input logic [1:0] tn_m,
        input logic [1:0] tn_w,
        input logic [1:0] tuse
    );
        logic [2:0] res;
        logic [1:0] sel;
        logic [1:0] tn;
        logic       hit;
        res = '0;
        sel = '0;
        tn  = '0;
        hit = 1'b0;
        if (hit_e) begin
            hit = 1'b1; tn = tn_e; sel = 2'd1;
        end else if (hit_m) begin
            hit = 1'b1; tn = tn_m; sel = 2'd2;
        end else if (hit_w) begin
            hit = 1'b1; tn = tn_w; sel = 2'd3;
        end
        res[2]   = hit && (tuse != TUSE_NONE) && (tn > tuse);
        res[1:0] = (hit && (tn == '0)) ? sel : '0;
        return res;
    endfunction

    // E operand select: M has priority over W, and a not-ready M match
    // blocks the stale W value.
    function automatic logic [1:0] e_eval(
        input logic       hit_m,
        input logic       hit_w,
        input logic [1:0] tn_m,
        input logic [1:0] tn_w
    );
        logic [1:0] sel;
        sel = '0;
        if (hit_m) begin
            sel = (tn_m == '0) ? 2'd1 : 2'd0;
        end else if (hit_w) begin
            sel = (tn_w == '0) ? 2'd2 : 2'd0;
        end
        return sel;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == '0) ? 2'd0 : v - 2'd1;
    endfunction

    logic [2:0] rs_res, rt_res;
    logic       rs_hit_e, rs_hit_m, rs_hit_w;
    logic       rt_hit_e, rt_hit_m, rt_hit_w;
    logic       ers_hit_m, ers_hit_w, ert_hit_m, ert_hit_w;
    logic       ers_used, ert_used;

    always_comb begin
        rs_hit_e = e_live && (d_rs != '0) && (e_a3_q == d_rs);
        rs_hit_m = m_live && (d_rs != '0) && (m_a3_q == d_rs);
        rs_hit_w = w_live && (d_rs != '0) && (w_a3_q == d_rs);
        rt_hit_e = e_live && (d_rt != '0) && (e_a3_q == d_rt);
        rt_hit_m = m_live && (d_rt != '0) && (m_a3_q == d_rt);
        rt_hit_w = w_live && (d_rt != '0) && (w_a3_q == d_rt);

        rs_res = d_eval(rs_hit_e, rs_hit_m, rs_hit_w,
                        e_tnew_q, m_tnew_q, w_tnew_q, d_tuse_rs);
        rt_res = d_eval(rt_hit_e, rt_hit_m, rt_hit_w,
                        e_tnew_q, m_tnew_q, w_tnew_q, d_tuse_rt);

        stall    = rs_res[2] | rt_res[2];
        fwd_rs_d = rs_res[1:0];
        fwd_rt_d = rt_res[1:0];

        // Sources that the E instruction never reads are not forwarded
        ers_used  = (e_tuse_rs_q != TUSE_NONE) && (e_rs_q != '0);
        ert_used  = (e_tuse_rt_q != TUSE_NONE) && (e_rt_q != '0);
        ers_hit_m = ers_used && m_live && (m_a3_q == e_rs_q);
        ers_hit_w = ers_used && w_live && (w_a3_q == e_rs_q);
        ert_hit_m = ert_used && m_live && (m_a3_q == e_rt_q);
        ert_hit_w = ert_used && w_live && (w_a3_q == e_rt_q);

        fwd_rs_e = e_eval(ers_hit_m, ers_hit_w, m_tnew_q, w_tnew_q);
        fwd_rt_e = e_eval(ert_hit_m, ert_hit_w, m_tnew_q, w_tnew_q);

        fwd_rt_m = (m_rt_q != '0) && w_live && (w_a3_q == m_rt_q);

        stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_a3_q      <= '0;
            e_rs_q      <= '0;
            e_rt_q      <= '0;
            e_tnew_q    <= '0;
            e_tuse_rs_q <= TUSE_NONE;
            e_tuse_rt_q <= TUSE_NONE;
            e_wr_q      <= 1'b0;
            m_a3_q      <= '0;
            m_rt_q      <= '0;
            m_tnew_q    <= '0;
            m_wr_q      <= 1'b0;
            w_a3_q      <= '0;
            w_tnew_q    <= '0;
            w_wr_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (stall) begin
                // Bubble: no write, no sources
                e_a3_q      <= '0;
                e_rs_q      <= '0;
                e_rt_q      <= '0;
                e_tnew_q    <= '0;
                e_tuse_rs_q <= TUSE_NONE;
                e_tuse_rt_q <= TUSE_NONE;
                e_wr_q      <= 1'b0;
            end else begin
                e_a3_q      <= d_a3;
                e_rs_q      <= d_rs;
                e_rt_q      <= d_rt;
                e_tnew_q    <= d_tnew;
                e_tuse_rs_q <= d_tuse_rs;
                e_tuse_rt_q <= d_tuse_rt;
                e_wr_q      <= d_regwrite && (d_a3 != '0);
            end
            m_a3_q      <= e_a3_q;
            m_rt_q      <= e_rt_q;
            m_tnew_q    <= sat_dec(e_tnew_q);
            m_wr_q      <= e_wr_q;
            w_a3_q      <= m_a3_q;
            w_tnew_q    <= sat_dec(m_tnew_q);
            w_wr_q      <= m_wr_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Each step drives one D-stage
// instruction, pushes the hand-derived expected outputs, and pops and
// compares them once the combinational outputs have settled.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tur;
        logic [1:0] tut;
        logic [1:0] tnew;
        logic [4:0] a3;
        logic       rw;
    } stim_t;

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] frsd;
        logic [1:0] frtd;
        logic [1:0] frse;
        logic [1:0] frte;
        logic       frtm;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [4:0]       d_rs, d_rt, d_a3;
    logic [1:0]       d_tuse_rs, d_tuse_rt, d_tnew;
    logic             d_regwrite;
    logic             stall;
    logic [1:0]       fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic             fwd_rt_m;
    logic [CNT_W-1:0] stall_cnt;

    int unsigned vec_cnt;
    int unsigned err_cnt;
    logic [CNT_W-1:0] exp_cnt;
    exp_t sb_q[$];

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_tnew     (d_tnew),
        .d_a3       (d_a3),
        .d_regwrite (d_regwrite),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e),
        .fwd_rt_m   (fwd_rt_m),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] tur, input logic [1:0] tut,
                                 input logic [1:0] tnew, input logic [4:0] a3,
                                 input logic rw);
        stim_t s;
        s.rs = rs; s.rt = rt; s.tur = tur; s.tut = tut;
        s.tnew = tnew; s.a3 = a3; s.rw = rw;
        return s;
    endfunction

    function automatic exp_t ex(input string tag, input logic st,
                                input logic [1:0] frsd, input logic [1:0] frtd,
                                input logic [1:0] frse, input logic [1:0] frte,
                                input logic frtm);
        exp_t e;
        e.tag = tag; e.stall = st; e.frsd = frsd; e.frtd = frtd;
        e.frse = frse; e.frte = frte; e.frtm = frtm; e.cnt = '0;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        d_rs = s.rs; d_rt = s.rt; d_tuse_rs = s.tur; d_tuse_rt = s.tut;
        d_tnew = s.tnew; d_a3 = s.a3; d_regwrite = s.rw;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_eq({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
        check_eq({e.tag, ".fwd_rs_d"}, 32'(fwd_rs_d), 32'(e.frsd));
        check_eq({e.tag, ".fwd_rt_d"}, 32'(fwd_rt_d), 32'(e.frtd));
        check_eq({e.tag, ".fwd_rs_e"}, 32'(fwd_rs_e), 32'(e.frse));
        check_eq({e.tag, ".fwd_rt_e"}, 32'(fwd_rt_e), 32'(e.frte));
        check_eq({e.tag, ".fwd_rt_m"}, 32'(fwd_rt_m), 32'(e.frtm));
        check_eq({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    endtask

    // One D-stage cycle: drive after the falling edge, check before the
    // next rising edge, which then advances the shadow pipeline.
    task automatic step(input stim_t s, input exp_t e);
        @(negedge clk);
        drive(s);
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        if (e.stall) exp_cnt = exp_cnt + 1;
        #2;
        compare_out();
    endtask

    stim_t nop;
    stim_t s_lw1, s_addu2, s_addu4, s_beq4, s_lw5, s_jr5;
    stim_t s_ori6, s_addu6, s_use6, s_ori14, s_addu14, s_sw14, s_lw7, s_sw7;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        exp_cnt = '0;

        nop      = mk(5'd0,  5'd0,  2'd3, 2'd3, 2'd0, 5'd0,  1'b0);
        s_lw1    = mk(5'd29, 5'd0,  2'd1, 2'd3, 2'd2, 5'd1,  1'b1);
        s_addu2  = mk(5'd1,  5'd3,  2'd1, 2'd1, 2'd1, 5'd2,  1'b1);
        s_addu4  = mk(5'd10, 5'd11, 2'd1, 2'd1, 2'd1, 5'd4,  1'b1);
        s_beq4   = mk(5'd4,  5'd0,  2'd0, 2'd0, 2'd0, 5'd0,  1'b0);
        s_lw5    = mk(5'd29, 5'd0,  2'd1, 2'd3, 2'd2, 5'd5,  1'b1);
        s_jr5    = mk(5'd5,  5'd0,  2'd0, 2'd3, 2'd0, 5'd0,  1'b0);
        s_ori6   = mk(5'd0,  5'd0,  2'd1, 2'd3, 2'd1, 5'd6,  1'b1);
        s_addu6  = mk(5'd12, 5'd13, 2'd1, 2'd1, 2'd1, 5'd6,  1'b1);
        s_use6   = mk(5'd6,  5'd0,  2'd1, 2'd3, 2'd1, 5'd9,  1'b1);
        s_ori14  = mk(5'd0,  5'd0,  2'd1, 2'd3, 2'd1, 5'd14, 1'b1);
        s_addu14 = mk(5'd12, 5'd13, 2'd1, 2'd1, 2'd1, 5'd14, 1'b1);
        s_sw14   = mk(5'd0,  5'd14, 2'd3, 2'd2, 2'd0, 5'd0,  1'b0);
        s_lw7    = mk(5'd29, 5'd0,  2'd1, 2'd3, 2'd2, 5'd7,  1'b1);
        s_sw7    = mk(5'd8,  5'd7,  2'd1, 2'd2, 2'd0, 5'd0,  1'b0);

        // Reset with hazard-looking D inputs: empty shadows, nothing fires
        reset = 1'b1;
        drive(s_jr5);
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(ex("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        compare_out();
        @(negedge clk);
        reset = 1'b0;

        // lw $1 ; addu $2,$1,$3
        step(s_lw1,   ex("lwuse.c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_addu2, ex("lwuse.c2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_addu2, ex("lwuse.c3", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(nop,     ex("lwuse.c4", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0));
        repeat (3) step(nop, ex("flush1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

        // addu $4 ; beq $4,$0
        step(s_addu4, ex("beq.c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_beq4,  ex("beq.c2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_beq4,  ex("beq.c3", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0));
        step(nop,     ex("beq.c4", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0));
        repeat (2) step(nop, ex("flush2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

        // lw $5 ; jr $5 -- two stall cycles, then W forward
        step(s_lw5, ex("jr.c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_jr5, ex("jr.c2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_jr5, ex("jr.c3", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_jr5, ex("jr.c4", 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0));
        repeat (2) step(nop, ex("flush3", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

        // ori $6 in W, addu $6 in M, D uses $6: M wins for D forward
        step(s_ori6,  ex("mw.c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_addu6, ex("mw.c2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(nop,     ex("mw.c3", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_use6,  ex("mw.c4", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0));
        step(nop,     ex("mw.c5", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0));

        // ori $14 ; addu $14 ; sw $14: not-ready E match hides ready M match,
        // then M beats W for E forward, then W feeds DM write data
        step(s_ori14,  ex("e14.c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_addu14, ex("e14.c2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_sw14,   ex("e14.c3", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(nop,      ex("e14.c4", 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0));
        step(nop,      ex("e14.c5", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));

        // lw $7 ; sw $7,0($8): no stall, then W -> DM write data
        step(s_lw7, ex("sw.c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_sw7, ex("sw.c2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(nop,   ex("sw.c3", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(nop,   ex("sw.c4", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
        step(nop,   ex("sw.c5", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

        // Reset arriving while a lw-use stall is pending
        step(s_lw1,   ex("rst.c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        step(s_addu2, ex("rst.c2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        reset = 1'b1;
        exp_cnt = '0;
        #1;
        sb_q.push_back(ex("rst.async", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        compare_out();
        @(negedge clk);
        reset = 1'b0;
        step(s_addu2, ex("rst.after", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
